// File: rtl/bnn_pkg.sv
// Shared BNN pipeline constants: layer state encodings, MEM1 layout and
// per-layer output region decode.
package bnn_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 9;

  localparam logic [ADDR_W-1:0] MEM1_OFFSET = 9'd252;

  localparam logic [2:0] IDLE_ST  = 3'd0;
  localparam logic [2:0] READ_ST  = 3'd1;
  localparam logic [2:0] CONV1_ST = 3'd2;
  localparam logic [2:0] CONV2_ST = 3'd3;
  localparam logic [2:0] CONV3_ST = 3'd4;
  localparam logic [2:0] FCL1_ST  = 3'd5;
  localparam logic [2:0] FCL2_ST  = 3'd6;

  localparam logic [CNT_W-1:0] CONV1_LEN = 9'd252;
  localparam logic [CNT_W-1:0] CONV2_LEN = 9'd48;
  localparam logic [CNT_W-1:0] CONV3_LEN = 9'd112;
  localparam logic [CNT_W-1:0] FCL1_LEN  = 9'd12;

  typedef struct packed {
    logic              writing;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  length;
  } regionT;

  // Each writing layer fills the region that the following layer reads back.
  function automatic regionT regionDecode(input logic [2:0] layerState);
    regionT r;
    r = '{writing: 1'b0, base: '0, length: '0};
    case (layerState)
      CONV1_ST: r = '{writing: 1'b1, base: '0,          length: CONV1_LEN};
      CONV2_ST: r = '{writing: 1'b1, base: MEM1_OFFSET, length: CONV2_LEN};
      CONV3_ST: r = '{writing: 1'b1, base: '0,          length: CONV3_LEN};
      FCL1_ST:  r = '{writing: 1'b1, base: MEM1_OFFSET, length: FCL1_LEN};
      default:  r = '{writing: 1'b0, base: '0,          length: '0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem1_write_controller_if.sv
// Layer-result input stream and MEM1 write port of mem1_write_controller.
interface mem1_write_controller_if;

  logic [2:0]                  iSTATE;
  logic                        iVALID;
  logic [bnn_pkg::DATA_W-1:0]  iDATA;
  logic                        oWR_EN;
  logic [bnn_pkg::ADDR_W-1:0]  oWR_ADDR;
  logic [bnn_pkg::DATA_W-1:0]  oWR_DATA;
  logic                        oDONE;
  logic                        oOVF;

  modport master (
    output iSTATE, iVALID, iDATA,
    input  oWR_EN, oWR_ADDR, oWR_DATA, oDONE, oOVF
  );

  modport slave (
    input  iSTATE, iVALID, iDATA,
    output oWR_EN, oWR_ADDR, oWR_DATA, oDONE, oOVF
  );

endinterface

// File: rtl/mem1_region_counter.sv
// Word counter for one MEM1 output region; length selects the active layer.
module mem1_region_counter
  import bnn_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] length,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] countQ;

  // A clear takes effect in the same cycle so a word arriving with it lands at offset 0.
  assign count = clear ? '0 : countQ;
  assign last  = (count == length - 9'd1);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      countQ <= '0;
    end else begin
      countQ <= count + CNT_W'(inc);
    end
  end

endmodule

// File: rtl/mem1_write_controller.sv
// Packs valid layer result words into consecutive MEM1 addresses of the
// region selected by the layer state, flagging completion and overflow.
module mem1_write_controller
  import bnn_pkg::*;
(
  input logic                    iCLK,
  input logic                    iRST,
  mem1_write_controller_if.slave bus
);

  localparam logic [1:0] FSM_IDLE  = 2'd0;
  localparam logic [1:0] FSM_WRITE = 2'd1;
  localparam logic [1:0] FSM_FULL  = 2'd2;

  logic [2:0]        stateQ;
  logic [1:0]        fsmQ, fsmD, fsmCur;
  logic              stateChange, accept, last, ovfD;
  logic [CNT_W-1:0]  count;
  regionT            region;

  logic              wrEnQ, doneQ, ovfQ;
  logic [ADDR_W-1:0] wrAddrQ;
  logic [DATA_W-1:0] wrDataQ;

  assign region      = regionDecode(bus.iSTATE);
  assign stateChange = (bus.iSTATE != stateQ);

  // A state change restarts the FSM this very cycle, so its word uses the new region.
  always_comb begin
    fsmCur = fsmQ;
    if (stateChange || fsmQ == FSM_IDLE) begin
      fsmCur = region.writing ? FSM_WRITE : FSM_IDLE;
    end
  end

  assign accept = (fsmCur == FSM_WRITE) && bus.iVALID;
  assign fsmD   = (accept && last) ? FSM_FULL : fsmCur;
  assign ovfD   = (stateChange ? 1'b0 : ovfQ) | ((fsmCur == FSM_FULL) && bus.iVALID);

  mem1_region_counter u_counter (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .clear  (stateChange),
    .inc    (accept),
    .length (region.length),
    .count  (count),
    .last   (last)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      stateQ  <= IDLE_ST;
      fsmQ    <= FSM_IDLE;
      wrEnQ   <= 1'b0;
      doneQ   <= 1'b0;
      ovfQ    <= 1'b0;
      wrAddrQ <= '0;
      wrDataQ <= '0;
    end else begin
      stateQ <= bus.iSTATE;
      fsmQ   <= fsmD;
      wrEnQ  <= accept;
      doneQ  <= accept && last;
      ovfQ   <= ovfD;
      if (accept) begin
        wrAddrQ <= region.base + count;
        wrDataQ <= bus.iDATA;
      end
    end
  end

  assign bus.oWR_EN   = wrEnQ;
  assign bus.oWR_ADDR = wrAddrQ;
  assign bus.oWR_DATA = wrDataQ;
  assign bus.oDONE    = doneQ;
  assign bus.oOVF     = ovfQ;

endmodule

// File: tb/tb_mem1_write_controller.sv
// Directed self-checking bench for mem1_write_controller.
module tb_mem1_write_controller;
  import bnn_pkg::*;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem1_write_controller_if bus ();

  mem1_write_controller dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  // Drive inputs, clock once, then sample 1 time unit after the edge.
  task automatic cycle(input logic [2:0] st, input logic vld, input logic [15:0] dat);
    bus.iSTATE = st;
    bus.iVALID = vld;
    bus.iDATA  = dat;
    @(posedge iCLK);
    #1;
  endtask

  task automatic expectWrite(input string name, input logic en, input logic [8:0] addr,
                             input logic [15:0] dat, input logic done, input logic ovf);
    checks++;
    if (bus.oWR_EN !== en || bus.oDONE !== done || bus.oOVF !== ovf ||
        (en && (bus.oWR_ADDR !== addr || bus.oWR_DATA !== dat))) begin
      errors++;
      $display("FAIL %s: got en=%b addr=%0d data=%h done=%b ovf=%b, want en=%b addr=%0d data=%h done=%b ovf=%b",
               name, bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oDONE, bus.oOVF,
               en, addr, dat, done, ovf);
    end
  endtask

  task automatic test_reset();
    bus.iSTATE = IDLE_ST;
    bus.iVALID = 1'b0;
    bus.iDATA  = '0;
    #3;
    checks++;
    if ({bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oDONE, bus.oOVF} !== 28'd0) begin
      errors++;
      $display("FAIL reset: got en=%b addr=%0d data=%h done=%b ovf=%b, want all 0",
               bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oDONE, bus.oOVF);
    end
    @(negedge iCLK);
    iRST = 1'b0;
    cycle(IDLE_ST, 1'b0, 16'h0);
    expectWrite("reset_idle", 1'b0, 9'd0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_conv1();
    for (int k = 0; k < 252; k++) begin
      cycle(CONV1_ST, 1'b1, 16'(k));
      expectWrite("conv1_word", 1'b1, 9'(k), 16'(k), (k == 251), 1'b0);
    end
    cycle(CONV1_ST, 1'b0, 16'h0);
    expectWrite("conv1_after", 1'b0, 9'd0, 16'h0, 1'b0, 1'b0);
    cycle(IDLE_ST, 1'b0, 16'h0);
  endtask

  task automatic test_conv2_gaps();
    for (int k = 0; k < 48; k++) begin
      int gaps;
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        cycle(CONV2_ST, 1'b0, 16'hDEAD);
        expectWrite("conv2_gap", 1'b0, 9'd0, 16'h0, 1'b0, 1'b0);
      end
      cycle(CONV2_ST, 1'b1, 16'hA000 + 16'(k));
      expectWrite("conv2_word", 1'b1, 9'd252 + 9'(k), 16'hA000 + 16'(k), (k == 47), 1'b0);
    end
  endtask

  task automatic test_fcl1_overflow();
    for (int k = 0; k < 14; k++) begin
      cycle(FCL1_ST, 1'b1, 16'hB000 + 16'(k));
      if (k < 12) begin
        expectWrite("fcl1_word", 1'b1, 9'd252 + 9'(k), 16'hB000 + 16'(k), (k == 11), 1'b0);
      end else begin
        expectWrite("fcl1_surplus", 1'b0, 9'd0, 16'h0, 1'b0, 1'b1);
      end
    end
    cycle(FCL1_ST, 1'b0, 16'h0);
    expectWrite("fcl1_ovf_sticky", 1'b0, 9'd0, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    for (int k = 0; k < 50; k++) begin
      cycle(CONV3_ST, 1'b1, 16'hC000 + 16'(k));
      expectWrite("conv3_word", 1'b1, 9'(k), 16'hC000 + 16'(k), 1'b0, 1'b0);
    end
    cycle(CONV2_ST, 1'b1, 16'h1234);
    expectWrite("abort_switch", 1'b1, 9'd252, 16'h1234, 1'b0, 1'b0);
    cycle(CONV2_ST, 1'b1, 16'h1235);
    expectWrite("abort_next", 1'b1, 9'd253, 16'h1235, 1'b0, 1'b0);
  endtask

  task automatic test_idle_states();
    logic [2:0] sts [4];
    sts = '{IDLE_ST, READ_ST, FCL2_ST, 3'd7};
    foreach (sts[i]) begin
      for (int p = 0; p < 3; p++) begin
        cycle(sts[i], 1'b1, 16'hEE00 + 16'(p));
        expectWrite("idle_no_write", 1'b0, 9'd0, 16'h0, 1'b0, 1'b0);
        cycle(sts[i], 1'b0, 16'h0);
        expectWrite("idle_gap", 1'b0, 9'd0, 16'h0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 100; k++) begin
      cycle(CONV1_ST, 1'b1, 16'hD000 + 16'(k));
      expectWrite("rst_pre_word", 1'b1, 9'(k), 16'hD000 + 16'(k), 1'b0, 1'b0);
    end
    #1;
    iRST = 1'b1;
    #1;
    checks++;
    if ({bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oDONE, bus.oOVF} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset: got en=%b addr=%0d data=%h done=%b ovf=%b, want all 0",
               bus.oWR_EN, bus.oWR_ADDR, bus.oWR_DATA, bus.oDONE, bus.oOVF);
    end
    cycle(CONV1_ST, 1'b1, 16'hFFFF);
    @(negedge iCLK);
    iRST = 1'b0;
    cycle(CONV1_ST, 1'b1, 16'h5555);
    expectWrite("rst_resume", 1'b1, 9'd0, 16'h5555, 1'b0, 1'b0);
    cycle(CONV1_ST, 1'b1, 16'h5556);
    expectWrite("rst_resume_next", 1'b1, 9'd1, 16'h5556, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_conv1();
    test_conv2_gaps();
    test_fcl1_overflow();
    test_abort();
    test_idle_states();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
